mem_req_arbiter: RTL

- Shares one sram-like memory port between the instruction-fetch master and the data master (the execute stage's load/store request).
- Arbitrates address-phase requests with data priority and a starvation guard.
- Tracks outstanding accepted requests in order and routes each `data_ok`/`rdata` back to its originator.
- Sits between the CPU pipeline and the AXI bridge.

---
 rtl/arb_pkg.sv | 11 +
 rtl/req_tag_fifo.sv | 57 +++++
 rtl/mem_req_arbiter.sv | 136 +++++++++++++
 3 files changed

// File: rtl/arb_pkg.sv
// Shared types for the memory-port arbiter: master tags, FSM states and
// the size codes used by the execute stage.
package arb_pkg;
    typedef enum logic {TAG_INST = 1'b0, TAG_DATA = 1'b1} tag_e;

    typedef enum logic [1:0] {ST_IDLE = 2'd0, ST_HOLD_D = 2'd1, ST_HOLD_I = 2'd2} arb_st_e;

    localparam logic [1:0] SIZE_BYTE = 2'd0;
    localparam logic [1:0] SIZE_HALF = 2'd1;
    localparam logic [1:0] SIZE_WORD = 2'd2;
endpackage

// File: rtl/req_tag_fifo.sv
// In-order FIFO of 1-bit originator tags for accepted-but-unanswered requests.
module req_tag_fifo
    import arb_pkg::*;
#(
    parameter int DEPTH = 4,
    localparam int PW = $clog2(DEPTH),
    localparam int CW = $clog2(DEPTH + 1)
) (
    input  logic          clk,
    input  logic          resetn,
    input  logic          push_i,
    input  tag_e          push_tag_i,
    input  logic          pop_i,
    output tag_e          head_o,
    output logic [CW-1:0] cnt_o,
    output logic          full_o,
    output logic          empty_o
);
    logic [DEPTH-1:0] tag_q;
    logic [PW-1:0]    wr_ptr_q, rd_ptr_q;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             do_push, do_pop;

    assign full_o  = (cnt_q == CW'(DEPTH));
    assign empty_o = (cnt_q == '0);
    assign cnt_o   = cnt_q;
    assign head_o  = tag_e'(tag_q[rd_ptr_q]);

    // A push into a full FIFO is only legal when the head leaves that same cycle.
    assign do_push = push_i & (~full_o | pop_i);
    assign do_pop  = pop_i & ~empty_o;

    always_comb begin
        cnt_d = cnt_q;
        case ({do_push, do_pop})
            2'b10:   cnt_d = cnt_q + CW'(1);
            2'b01:   cnt_d = cnt_q - CW'(1);
            default: cnt_d = cnt_q;
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            tag_q    <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            if (do_push) begin
                tag_q[wr_ptr_q] <= push_tag_i;
                wr_ptr_q        <= wr_ptr_q + PW'(1);
            end
            if (do_pop) rd_ptr_q <= rd_ptr_q + PW'(1);
            cnt_q <= cnt_d;
        end
    end
endmodule

// File: rtl/mem_req_arbiter.sv
// Shares one sram-like port between fetch and data masters: data priority with
// a starvation guard, held grants, and in-order routing of responses.
module mem_req_arbiter
    import arb_pkg::*;
#(
    parameter int OUT_DEPTH = 4,
    parameter int MAX_D_RUN = 4
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        inst_req,
    input  logic        inst_wr,
    input  logic [1:0]  inst_size,
    input  logic [3:0]  inst_wstrb,
    input  logic [31:0] inst_addr,
    input  logic [31:0] inst_wdata,
    output logic        inst_addr_ok,
    output logic        inst_data_ok,
    output logic [31:0] inst_rdata,
    input  logic        data_req,
    input  logic        data_wr,
    input  logic [1:0]  data_size,
    input  logic [3:0]  data_wstrb,
    input  logic [31:0] data_addr,
    input  logic [31:0] data_wdata,
    output logic        data_addr_ok,
    output logic        data_data_ok,
    output logic [31:0] data_rdata,
    output logic        mem_req,
    output logic        mem_wr,
    output logic [1:0]  mem_size,
    output logic [3:0]  mem_wstrb,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic        mem_addr_ok,
    input  logic        mem_data_ok,
    input  logic [31:0] mem_rdata,
    output logic        err_unexp_ok
);
    localparam int DW = $clog2(MAX_D_RUN + 1);
    localparam int CW = $clog2(OUT_DEPTH + 1);

    arb_st_e       st_q, st_d;
    logic [DW-1:0] drun_q, drun_d;
    logic          err_q, err_d;
    tag_e          sel, head;
    logic          req_c, accept, fifo_full, fifo_empty;
    logic [CW-1:0] tag_cnt;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            st_q   <= ST_IDLE;
            drun_q <= '0;
            err_q  <= 1'b0;
        end else begin
            st_q   <= st_d;
            drun_q <= drun_d;
            err_q  <= err_d;
        end
    end

    // Output process: selection and request; HOLD states freeze the chosen master.
    always_comb begin
        sel   = TAG_DATA;
        req_c = 1'b0;
        case (st_q)
            ST_HOLD_D: begin sel = TAG_DATA; req_c = 1'b1; end
            ST_HOLD_I: begin sel = TAG_INST; req_c = 1'b1; end
            default: begin
                if (!data_req || (inst_req && drun_q == DW'(MAX_D_RUN))) sel = TAG_INST;
                req_c = (inst_req | data_req) & ~fifo_full;
            end
        endcase
    end

    always_comb begin
        st_d = st_q;
        case (st_q)
            ST_IDLE:   if (req_c && !mem_addr_ok) st_d = (sel == TAG_DATA) ? ST_HOLD_D : ST_HOLD_I;
            ST_HOLD_D,
            ST_HOLD_I: if (mem_addr_ok) st_d = ST_IDLE;
            default:   st_d = ST_IDLE;
        endcase
    end

    assign accept = req_c & mem_addr_ok;

    always_comb begin
        drun_d = drun_q;
        if (!inst_req || (accept && sel == TAG_INST))
            drun_d = '0;
        else if (accept && drun_q != DW'(MAX_D_RUN))
            drun_d = drun_q + DW'(1);
    end

    assign err_d = err_q | (mem_data_ok & fifo_empty);

    req_tag_fifo #(.DEPTH(OUT_DEPTH)) u_fifo (
        .clk        (clk),
        .resetn     (resetn),
        .push_i     (accept),
        .push_tag_i (sel),
        .pop_i      (mem_data_ok),
        .head_o     (head),
        .cnt_o      (tag_cnt),
        .full_o     (fifo_full),
        .empty_o    (fifo_empty)
    );

    // Every output is gated by resetn so combinational paths are quiet in reset.
    always_comb begin
        mem_req   = req_c & resetn;
        mem_wr    = 1'b0;
        mem_size  = '0;
        mem_wstrb = '0;
        mem_addr  = '0;
        mem_wdata = '0;
        if (mem_req) begin
            if (sel == TAG_DATA) begin
                mem_wr = data_wr; mem_size = data_size; mem_wstrb = data_wstrb;
                mem_addr = data_addr; mem_wdata = data_wdata;
            end else begin
                mem_wr = inst_wr; mem_size = inst_size; mem_wstrb = inst_wstrb;
                mem_addr = inst_addr; mem_wdata = inst_wdata;
            end
        end
    end

    assign inst_addr_ok = mem_req & mem_addr_ok & (sel == TAG_INST);
    assign data_addr_ok = mem_req & mem_addr_ok & (sel == TAG_DATA);
    assign inst_data_ok = resetn & mem_data_ok & (tag_cnt != '0) & (head == TAG_INST);
    assign data_data_ok = resetn & mem_data_ok & (tag_cnt != '0) & (head == TAG_DATA);
    assign inst_rdata   = resetn ? mem_rdata : '0;
    assign data_rdata   = resetn ? mem_rdata : '0;
    assign err_unexp_ok = err_q & resetn;
endmodule
